ifetch_pc_unit: RTL and testbench

// - Instruction-fetch and program-counter stage feeding the control-unit FSM.
// - Runs the instruction-bus handshake whenever the FSM requests a fetch (cyc_i & stb_i).
// - Holds the instruction register (IR) and returns op/func fields and fetch ack to the FSM.
// - Applies the FSM's PC operations: increment, branch, jump/jsb, ret, int, reti.

---
 rtl/ifetch_pc_unit_pkg.sv | 29 ++
 rtl/ifetch_pc_unit_if.sv | 15 +
 rtl/ifetch_pc_unit_ret_addr_stack.sv | 50 +++++
 rtl/ifetch_pc_unit.sv | 145 ++++++++++++++
 tb/tb_ifetch_pc_unit.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ifetch_pc_unit_pkg.sv
// Shared constants, opcode decode helpers and fetch FSM state type for the
// instruction-fetch / program-counter stage.
package ifetch_pc_unit_pkg;

  localparam int unsigned CPU_PC_W = 12;
  localparam int unsigned CPU_IR_W = 18;

  localparam logic [3:0] PC_OP_INC = 4'd0;
  localparam logic [3:0] PC_OP_BR  = 4'd4;
  localparam logic [3:0] PC_OP_RET = 4'd10;

  // Jump is op[6:2], branch is op[6:1]
  localparam logic [4:0] OP_JUMP_MASK   = 5'b11110;
  localparam logic [5:0] OP_BRANCH_MASK = 6'b111110;

  typedef enum logic {
    FETCH_IDLE,
    FETCH_REQ
  } fetch_st_e;

  function automatic logic is_jump(input logic [6:0] op);
    return op[6:2] == OP_JUMP_MASK;
  endfunction

  function automatic logic is_branch(input logic [6:0] op);
    return op[6:1] == OP_BRANCH_MASK;
  endfunction

endpackage

// File: rtl/ifetch_pc_unit_if.sv
// Instruction-bus interface: address/cycle/strobe from the fetch stage,
// acknowledge and read data from the instruction memory.
interface ifetch_pc_unit_if #(
  parameter int unsigned PC_W = 12,
  parameter int unsigned IR_W = 18
);
  logic [PC_W-1:0] adr;
  logic            cyc;
  logic            stb;
  logic            ack;
  logic [IR_W-1:0] dat;

  modport master (output adr, cyc, stb, input ack, dat);
  modport slave  (input adr, cyc, stb, output ack, dat);
endinterface

// File: rtl/ifetch_pc_unit_ret_addr_stack.sv
// Return-address stack: push discards when full, pop when empty reads 0;
// both set a sticky error. Push+pop together replaces the top entry.
module ret_addr_stack #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         empty,
  output logic         err
);
  localparam int unsigned SP_W = $clog2(DEPTH);

  logic [W-1:0]    mem [DEPTH];
  logic [SP_W:0]   sp;
  logic [SP_W-1:0] top_idx;
  logic            full;

  assign full    = sp == (SP_W+1)'(DEPTH);
  assign empty   = sp == '0;
  assign top_idx = sp[SP_W-1:0] - SP_W'(1);
  assign rdata   = empty ? '0 : mem[top_idx];

  always_ff @(posedge clk) begin
    if (push && pop && !empty)
      mem[top_idx] <= wdata;
    else if (push && (pop || !full))
      mem[sp[SP_W-1:0]] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp  <= '0;
      err <= 1'b0;
    end else if (push && pop) begin
      if (empty) sp <= sp + (SP_W+1)'(1);
    end else if (push) begin
      if (full) err <= 1'b1;
      else      sp  <= sp + (SP_W+1)'(1);
    end else if (pop) begin
      if (empty) err <= 1'b1;
      else       sp  <= sp - (SP_W+1)'(1);
    end
  end

endmodule

// File: rtl/ifetch_pc_unit.sv
// Instruction fetch + program counter stage. Optional fetch timeout is
// enabled by defining IFETCH_TIMEOUT_EN.
module ifetch_pc_unit
  import ifetch_pc_unit_pkg::*;
#(
  parameter int unsigned     PC_W        = CPU_PC_W,
  parameter int unsigned     IR_W        = CPU_IR_W,
  parameter int unsigned     STACK_DEPTH = 8,
  parameter logic [PC_W-1:0] INT_VECTOR  = 12'h001,
  parameter int unsigned     TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cyc_i,
  input  logic              stb_i,
  output logic              ack_o,
  ifetch_pc_unit_if.master  inst,
  output logic [IR_W-1:0]   ir_o,
  output logic [6:0]        op_o,
  output logic [2:0]        func_o,
  output logic [PC_W-1:0]   pc_o,
  input  logic              pc_en_i,
  input  logic [3:0]        pc_oper_i,
  input  logic              br_taken_i,
  input  logic              jsb_i,
  input  logic              ret_i,
  input  logic              int_i,
  input  logic              reti_i,
  output logic              stk_err_o,
  output logic              fetch_err_o
);

  fetch_st_e       st, st_nxt;
  logic [PC_W-1:0] pc, pc_nxt, int_pc, stk_rdata;
  logic [IR_W-1:0] ir;
  logic            ack_done, timeout, pc_op_en, push, pop;

  assign op_o   = ir[IR_W-1 -: 7];
  assign func_o = ir[2:0];
  assign ir_o   = ir;
  assign pc_o   = pc;

  // cyc/stb come straight from the state register, so they are registered
  // and drop asynchronously with reset.
  assign inst.adr = pc;
  assign inst.cyc = st == FETCH_REQ;
  assign inst.stb = st == FETCH_REQ;

  assign ack_done = (st == FETCH_REQ) && inst.ack;
  assign ack_o    = ack_done || timeout;

`ifdef IFETCH_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt;
  logic            fetch_err;

  assign timeout     = (st == FETCH_REQ) && !inst.ack && (to_cnt == TO_W'(TIMEOUT_CYC - 1));
  assign fetch_err_o = fetch_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt    <= '0;
      fetch_err <= 1'b0;
    end else if (timeout) begin
      to_cnt    <= '0;
      fetch_err <= 1'b1;
    end else if (st == FETCH_REQ && !inst.ack) begin
      to_cnt <= to_cnt + TO_W'(1);
    end else begin
      to_cnt <= '0;
    end
  end
`else
  assign timeout     = 1'b0;
  assign fetch_err_o = 1'b0;
`endif

  always_comb begin
    st_nxt = st;
    case (st)
      FETCH_IDLE: if (cyc_i && stb_i) st_nxt = FETCH_REQ;
      FETCH_REQ:  if (ack_done || timeout) st_nxt = FETCH_IDLE;
      default:    st_nxt = FETCH_IDLE;
    endcase
  end

  // Interrupt entry/return outrank the FSM's PC strobe, so stack traffic
  // is suppressed on those edges.
  assign pc_op_en = pc_en_i && !int_i && !reti_i;
  assign push     = pc_op_en && jsb_i;
  assign pop      = pc_op_en && ret_i;

  always_comb begin
    pc_nxt = pc;
    if (int_i) begin
      pc_nxt = INT_VECTOR;
    end else if (reti_i) begin
      pc_nxt = int_pc;
    end else if (pc_en_i) begin
      case (pc_oper_i)
        PC_OP_INC: pc_nxt = pc + PC_W'(1);
        PC_OP_BR: begin
          if (is_jump(op_o))
            pc_nxt = ir[PC_W-1:0];
          else if (is_branch(op_o) && br_taken_i)
            pc_nxt = pc + {{(PC_W-8){ir[7]}}, ir[7:0]};
        end
        PC_OP_RET: pc_nxt = stk_rdata;
        default:   pc_nxt = pc;
      endcase
    end else if (ack_done) begin
      pc_nxt = pc + PC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st     <= FETCH_IDLE;
      pc     <= '0;
      ir     <= '0;
      int_pc <= '0;
    end else begin
      st <= st_nxt;
      pc <= pc_nxt;
      if (int_i)        int_pc <= pc;
      if (ack_done)     ir     <= inst.dat;
      else if (timeout) ir     <= '0;
    end
  end

  ret_addr_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (PC_W)
  ) u_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (pc),
    .rdata (stk_rdata),
    .empty (),
    .err   (stk_err_o)
  );

endmodule

// File: tb/tb_ifetch_pc_unit.sv
// Directed + randomized bench for ifetch_pc_unit against a queue-based
// behavioural model of PC, IR, interrupt PC and return stack.
module tb_ifetch_pc_unit;
  localparam int unsigned PC_W = 12;
  localparam int unsigned IR_W = 18;

  logic            clk = 1'b0;
  logic            rst;
  logic            cyc_i, stb_i, ack_o;
  logic [IR_W-1:0] ir_o;
  logic [6:0]      op_o;
  logic [2:0]      func_o;
  logic [PC_W-1:0] pc_o;
  logic            pc_en_i, br_taken_i, jsb_i, ret_i, int_i, reti_i;
  logic [3:0]      pc_oper_i;
  logic            stk_err_o, fetch_err_o;

  always #5 clk = ~clk;

  ifetch_pc_unit_if #(.PC_W(PC_W), .IR_W(IR_W)) bus ();

  ifetch_pc_unit #(
    .PC_W(PC_W), .IR_W(IR_W), .STACK_DEPTH(8),
    .INT_VECTOR(12'h001), .TIMEOUT_CYC(16)
  ) dut (
    .clk(clk), .rst(rst), .cyc_i(cyc_i), .stb_i(stb_i), .ack_o(ack_o),
    .inst(bus.master), .ir_o(ir_o), .op_o(op_o), .func_o(func_o), .pc_o(pc_o),
    .pc_en_i(pc_en_i), .pc_oper_i(pc_oper_i), .br_taken_i(br_taken_i),
    .jsb_i(jsb_i), .ret_i(ret_i), .int_i(int_i), .reti_i(reti_i),
    .stk_err_o(stk_err_o), .fetch_err_o(fetch_err_o)
  );

  int unsigned vectors = 0, miscompares = 0;

  // Reference model state
  int unsigned m_pc, m_ir, m_int_pc;
  int unsigned m_stk[$];
  bit          m_stk_err, m_fetch_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_ir = 0; m_int_pc = 0; m_stk_err = 0; m_fetch_err = 0;
    m_stk.delete();
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".pc"}, 32'(pc_o), m_pc);
    chk({tag, ".ir"}, 32'(ir_o), m_ir);
    chk({tag, ".op"}, 32'(op_o), m_ir >> 11);
    chk({tag, ".func"}, 32'(func_o), m_ir % 8);
    chk({tag, ".stk_err"}, 32'(stk_err_o), 32'(m_stk_err));
    chk({tag, ".fetch_err"}, 32'(fetch_err_o), 32'(m_fetch_err));
    chk({tag, ".cyc"}, 32'(bus.cyc), 0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    cyc_i = 0; stb_i = 0; pc_en_i = 0; pc_oper_i = '0; br_taken_i = 0;
    jsb_i = 0; ret_i = 0; int_i = 0; reti_i = 0; bus.ack = 0; bus.dat = '0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic fetch(input int unsigned waits, input int unsigned dat);
    logic [PC_W-1:0] adr0;
    @(negedge clk);
    cyc_i = 1; stb_i = 1;
    @(negedge clk);
    cyc_i = 0; stb_i = 0;
    adr0 = bus.adr;
    chk("fetch.adr", 32'(adr0), m_pc);
    for (int unsigned i = 0; i < waits; i++) begin
      chk("fetch.wait_cyc", 32'(bus.cyc & bus.stb), 1);
      chk("fetch.wait_ack", 32'(ack_o), 0);
      @(negedge clk);
      chk("fetch.adr_stable", 32'(bus.adr), 32'(adr0));
    end
    chk("fetch.last_cyc", 32'(bus.cyc & bus.stb), 1);
    bus.ack = 1; bus.dat = IR_W'(dat);
    #1 chk("fetch.ack_o", 32'(ack_o), 1);
    @(negedge clk);
    bus.ack = 0;
    m_ir = dat % (1 << IR_W);
    m_pc = (m_pc + 1) % (1 << PC_W);
    check_state("fetch");
    chk("fetch.ack_o_drop", 32'(ack_o), 0);
  endtask

  task automatic pc_step(input logic [3:0] oper, input bit br, input bit jsb, input bit ret,
                         input bit intr, input bit reti);
    int unsigned old, top;
    int          disp;
    @(negedge clk);
    pc_en_i = 1; pc_oper_i = oper; br_taken_i = br; jsb_i = jsb; ret_i = ret;
    int_i = intr; reti_i = reti;
    old = m_pc;
    if (intr) begin
      m_int_pc = m_pc; m_pc = 1;
    end else if (reti) begin
      m_pc = m_int_pc;
    end else begin
      top = (m_stk.size() == 0) ? 0 : m_stk[m_stk.size()-1];
      if (oper == 0) m_pc = (m_pc + 1) % (1 << PC_W);
      else if (oper == 4) begin
        if ((m_ir >> 13) == 30) m_pc = m_ir % (1 << PC_W);
        else if ((m_ir >> 12) == 62 && br) begin
          disp = int'(m_ir % 256);
          if (disp >= 128) disp -= 256;
          m_pc = int'(unsigned'((int'(m_pc) + disp + (1 << PC_W)) % (1 << PC_W)));
        end
      end else if (oper == 10) m_pc = top;
      if (jsb && ret) begin
        if (m_stk.size() == 0) m_stk.push_back(old);
        else m_stk[m_stk.size()-1] = old;
      end else if (jsb) begin
        if (m_stk.size() == 8) m_stk_err = 1;
        else m_stk.push_back(old);
      end else if (ret) begin
        if (m_stk.size() == 0) m_stk_err = 1;
        else void'(m_stk.pop_back());
      end
    end
    @(negedge clk);
    pc_en_i = 0; pc_oper_i = '0; br_taken_i = 0; jsb_i = 0; ret_i = 0; int_i = 0; reti_i = 0;
    chk("step.pc", 32'(pc_o), m_pc);
    chk("step.stk_err", 32'(stk_err_o), 32'(m_stk_err));
  endtask

  function automatic int unsigned gen_instr();
    case ($urandom_range(3, 0))
      2:       return (30 << 13) | ($urandom & 32'h1FFF);
      3:       return (62 << 12) | ($urandom & 32'hFFF);
      default: return $urandom & 32'h3FFFF;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] opers [4];
    opers = '{4'd0, 4'd4, 4'd10, 4'd7};

    apply_reset();
    #1;
    check_state("reset");
    chk("reset.stb", 32'(bus.stb), 0);
    chk("reset.ack_o", 32'(ack_o), 0);

    fetch(0, 32'h3A5C1);
    chk("first.ir", 32'(ir_o), 32'h3A5C1);
    chk("first.pc", 32'(pc_o), 32'h001);
    fetch(3, 32'h12345);

    // Branch around PC 0x010
    fetch(1, (30 << 13) | 32'h00F);
    pc_step(4'd4, 0, 0, 0, 0, 0);
    fetch(0, (62 << 12) | 32'h0FC);
    pc_step(4'd4, 0, 0, 0, 0, 0);
    chk("br_not_taken", 32'(pc_o), 32'h010);
    pc_step(4'd4, 1, 0, 0, 0, 0);
    chk("br_taken", 32'(pc_o), 32'h00C);

    // jsb / ret
    fetch(2, (30 << 13) | 32'h010);
    pc_step(4'd4, 0, 0, 0, 0, 0);
    fetch(0, (30 << 13) | 32'h200);
    chk("jsb.pre_pc", 32'(pc_o), 32'h011);
    pc_step(4'd4, 0, 1, 0, 0, 0);
    chk("jsb.pc", 32'(pc_o), 32'h200);
    pc_step(4'd10, 0, 0, 1, 0, 0);
    chk("ret.pc", 32'(pc_o), 32'h011);
    for (int unsigned i = 0; i < 8; i++) pc_step(4'd4, 0, 1, 0, 0, 0);
    chk("push8.no_err", 32'(stk_err_o), 0);
    pc_step(4'd4, 0, 1, 0, 0, 0);
    chk("push9.err", 32'(stk_err_o), 1);
    pc_step(4'd10, 0, 1, 1, 0, 0);

    // Interrupts
    fetch(0, (30 << 13) | 32'h055);
    pc_step(4'd4, 0, 0, 0, 0, 0);
    pc_step(4'd0, 0, 0, 0, 1, 0);
    chk("int.pc", 32'(pc_o), 32'h001);
    pc_step(4'd0, 0, 0, 0, 0, 1);
    chk("reti.pc", 32'(pc_o), 32'h055);
    pc_step(4'd0, 0, 0, 0, 1, 0);
    chk("int_wins.pc", 32'(pc_o), 32'h001);

`ifdef IFETCH_TIMEOUT_EN
    begin
      int unsigned cycles, pulses;
      cycles = 0; pulses = 0;
      @(negedge clk); cyc_i = 1; stb_i = 1;
      @(negedge clk); cyc_i = 0; stb_i = 0;
      for (int unsigned i = 0; i < 40; i++) begin
        if (!bus.cyc) break;
        cycles++;
        if (ack_o) pulses++;
        @(negedge clk);
      end
      m_ir = 0; m_fetch_err = 1;
      chk("timeout.cycles", cycles, 16);
      chk("timeout.pulses", pulses, 1);
      check_state("timeout");
    end
`endif

    // Reset during a fetch, then a late ack
    @(negedge clk); cyc_i = 1; stb_i = 1;
    @(negedge clk); cyc_i = 0; stb_i = 0;
    chk("rstmid.cyc_before", 32'(bus.cyc), 1);
    #2 rst = 1'b0;
    #1 chk("rstmid.cyc_async", 32'(bus.cyc), 0);
    chk("rstmid.stb_async", 32'(bus.stb), 0);
    model_reset();
    @(negedge clk); rst = 1'b1;
    bus.ack = 1; bus.dat = 18'h2AAAA;
    #1 chk("rstmid.late_ack", 32'(ack_o), 0);
    @(negedge clk); bus.ack = 0;
    check_state("rstmid");

    // Randomized phase
    for (int unsigned n = 0; n < 120; n++) begin
      if ($urandom_range(1, 0) == 1)
        fetch($urandom_range(3, 0), gen_instr());
      else
        pc_step(opers[$urandom_range(3, 0)], 1'($urandom_range(1, 0)),
                $urandom_range(3, 0) == 0, $urandom_range(3, 0) == 0,
                $urandom_range(9, 0) == 0, $urandom_range(9, 0) == 0);
    end
    check_state("final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
